accum_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared accumulator datapath (DATA_W-bit operand into an ACC_W-bit running sum).
- Grants exactly one of NREQ requesters at a time.
- The granted requester streams operand beats over a valid/ready handshake until it flags the last beat.
- The block then presents the finished sum with the requester ID for one cycle and re-arbitrates.

---
 rtl/accum_arbiter.sv | 136 +++++++++++++
 tb/tb_accum_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/accum_arbiter.sv
// Round-robin arbiter feeding one shared accumulator; one burst per grant.
// Define ACCUM_ARB_SATURATE_EN to clamp the running sum at all-ones instead of wrapping.
module accum_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  acc_out_q, acc_out_d;

  logic [ID_W-1:0]   pick, cand;
  logic              found;
  int unsigned       idx;
  logic [DATA_W-1:0] beat_data;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_add;
  logic              beat;

  // Priority search starting at rr_ptr and wrapping through all requesters.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx  = (32'(rr_ptr_q) + k) % NREQ;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    beat_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == owner_q) beat_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  assign beat = (state_q == ACCUM) && req[owner_q];
  assign sum  = {1'b0, acc_q} + (ACC_W+1)'(beat_data);

`ifdef ACCUM_ARB_SATURATE_EN
  assign acc_add = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_add = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    out_id_d  = out_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ACCUM;
          grant_d = NREQ'(1) << pick;
          owner_d = pick;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_add;
          // Result is latched on the last beat so it is already stable during DONE.
          if (req_last[owner_q]) begin
            state_d   = DONE;
            grant_d   = '0;
            acc_out_d = acc_add;
            out_id_d  = owner_q;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = (owner_q == ID_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      out_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      out_id_q  <= out_id_d;
    end
  end

  assign req_ready = grant_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_out_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_accum_arbiter.sv
// Scoreboard bench for accum_arbiter: driver predicts winner and sum, monitor checks each result strobe.
module tb_accum_arbiter;
  localparam int NREQ = 4, DATA_W = 4, ACC_W = 8, ID_W = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic [NREQ-1:0]        req_last = '0;
  logic [NREQ-1:0]        req_ready, grant;
  logic                   busy, out_valid;
  logic [ACC_W-1:0]       acc_out;
  logic [ID_W-1:0]        out_id;

  accum_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ACC_W(ACC_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy), .acc_out(acc_out),
    .out_valid(out_valid), .out_id(out_id)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int sum; int edge_n;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   bq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   m_rr = 0;
  logic rst_seen = 1'b1;
  int   hold_sum = 0, hold_id = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: rotating priority over the requesting set, sum of the burst's operands.
  function automatic int pick(input logic [NREQ-1:0] c);
    for (int k = 0; k < NREQ; k++)
      if (c[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  function automatic int ref_sum();
    int s = 0;
    foreach (bq[i]) s += bq[i];
`ifdef ACCUM_ARB_SATURATE_EN
    return (s > (1 << ACC_W) - 1) ? (1 << ACC_W) - 1 : s;
`else
    return s % (1 << ACC_W);
`endif
  endfunction

  task automatic fill_const(input int n, input int v);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(v);
  endtask

  // Called at a negedge with the DUT idle; streams bq from the predicted winner.
  task automatic burst(input logic [NREQ-1:0] cont, input int stall_pct, input int forced);
    int w, k, n, t, b, stall_left;
    bit granted, stall;
    exp_t e;
    w = pick(cont); n = bq.size(); k = 0; granted = 0; stall_left = forced;
    e.id = w; e.sum = ref_sum(); e.edge_n = 0;
    for (t = 0; t < 400 && k < n; t++) begin
      check("ready_mask", 32'(req_ready & ~(NREQ'(1) << w)), 0);
      if (!granted && req_ready[w]) begin
        granted = 1;
        check("grant_latency", t, 1);
        check("grant_onehot", 32'(grant), 32'(NREQ'(1) << w));
      end
      req      = cont;
      req_data = (NREQ*DATA_W)'($urandom);
      req_last = NREQ'($urandom);
      stall = 0;
      if (granted) begin
        if (k == 1 && stall_left > 0) begin
          stall = 1;
          stall_left--;
        end else if ($urandom_range(99) < stall_pct) begin
          stall = 1;
        end
      end
      if (stall) req[w] = 1'b0;
      else begin
        req_data[w*DATA_W +: DATA_W] = DATA_W'(bq[k]);
        req_last[w] = (k == n - 1);
        if (granted) begin
          k++;
          if (k == n) begin
            e.edge_n = cyc + 1;
            exp_q.push_back(e);
          end
        end
      end
      @(negedge clk);
    end
    if (k < n) begin
      check("burst_done", k, n);
      req = '0;
      return;
    end
    check("grant_cleared", 32'(grant), 0);
    check("ready_cleared", 32'(req_ready), 0);
    req[w] = 1'b0;
    req_last = '0;
    for (b = 0; b < 4 && busy; b++) @(negedge clk);
    check("turnaround", b, 1);
    m_rr = (w + 1) % NREQ;
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      hold_sum = 0;
      hold_id  = 0;
      prev_ov  = 1'b0;
    end else begin
      if (out_valid) begin
        check("ov_width", 32'(prev_ov), 0);
        if (exp_q.size() == 0) check("unexpected_ov", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("out_id", 32'(out_id), mon_e.id);
          check("acc_out", 32'(acc_out), mon_e.sum);
          check("ov_latency", cyc, mon_e.edge_n);
          hold_sum = mon_e.sum;
          hold_id  = mon_e.id;
        end
      end else begin
        check("acc_out_hold", 32'(acc_out), hold_sum);
        check("out_id_hold", 32'(out_id), hold_id);
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w, n;
    logic [NREQ-1:0] cont;
    rst = 1'b1;
    req = '1;
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_acc_out", 32'(acc_out), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    req = '0;

    // Every requester always asking; single-beat bursts carrying their own index.
    for (int r = 0; r < 5; r++) begin
      w = pick(4'hF);
      fill_const(1, w);
      burst(4'hF, 0, 0);
    end

    bq.delete(); bq.push_back(3); bq.push_back(5); bq.push_back(7);
    burst(4'b0100, 0, 0);
    check("rr_after_req2", m_rr, 3);

    fill_const(1, 4);
    burst(4'b1000, 0, 0);
    bq.delete(); bq.push_back(2); bq.push_back(6);
    burst(4'b1001, 0, 3);
    fill_const(1, 9);
    burst(4'b1001, 0, 0);

    fill_const(20, 15);
    burst(4'b0010, 0, 0);

    for (int r = 0; r < 30; r++) begin
      cont = NREQ'($urandom_range(1, 15));
      n = $urandom_range(1, 6);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back($urandom_range(0, 15));
      burst(cont, 25, 0);
    end

    // Abort a burst from requester 1 by reset after two accepted beats.
    fill_const(1, 5);
    burst(4'b0001, 0, 0);
    req = 4'b0010;
    req_data = '0;
    req_data[DATA_W +: DATA_W] = 4'd1;
    req_last = '0;
    for (t = 0; t < 8 && !req_ready[1]; t++) @(negedge clk);
    check("rb_grant", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    check("rb_out_valid", 32'(out_valid), 0);
    check("rb_acc_out", 32'(acc_out), 0);
    check("rb_grant_zero", 32'(grant), 0);
    check("rb_busy", 32'(busy), 0);
    m_rr = 0;
    fill_const(2, 1);
    burst(4'hF, 0, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
